// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard codes from the hazard unit, pipeline-control FSM
// states and the ALU operand forwarding select encodings.
package cpu_types_pkg;

    typedef enum logic [2:0] {
        HZ_NONE     = 3'b000,
        HZ_FWD_MEM  = 3'b001,
        HZ_FWD_WB   = 3'b010,
        HZ_LOAD_USE = 3'b011,
        HZ_LOAD_WB  = 3'b100
    } hazard_t;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        BUBBLE = 3'd1,
        DWAIT  = 3'd2,
        IWAIT  = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

endpackage

// File: rtl/pipeline_control_if.sv
// Signal bundle between the pipeline-control block and the datapath.
interface pipeline_control_if #(
    parameter int STALL_CNT_W = 16
);
    logic [2:0]             src1_hazard_t;
    logic [2:0]             src2_hazard_t;
    logic                   ihit;
    logic                   dhit;
    logic                   dmem_req;
    logic                   branch_taken;
    logic                   halt;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   memwb_en;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic [1:0]             fwdA_sel;
    logic [1:0]             fwdB_sel;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_count;

    modport ctrl (
        input  src1_hazard_t, src2_hazard_t, ihit, dhit, dmem_req,
               branch_taken, halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, fwdA_sel, fwdB_sel,
               halted, stall_count
    );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline stall/flush/forward controller. A small FSM tracks load-use
// bubbles, instruction/data memory waits and halt; every output is decoded
// combinationally from the current state and the live inputs.
module pipeline_control
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input logic              CLK,
    input logic              nRST,
    pipeline_control_if.ctrl bus
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [STALL_CNT_W-1:0] stall_count_reg;

    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c;

    logic [2:0] src_code [2];
    logic [1:0] fwd_sel  [2];

    // Hazard code -> operand mux select; load-use and unused codes read the
    // register file because the bubble (or nothing) covers them.
    function automatic logic [1:0] fwd_decode(input logic [2:0] code);
        case (code)
            HZ_FWD_MEM: return FWD_EXMEM;
            HZ_FWD_WB:  return FWD_MEMWB;
            HZ_LOAD_WB: return FWD_MEMWB;
            default:    return FWD_REGFILE;
        endcase
    endfunction

    assign src_code[0] = bus.src1_hazard_t;
    assign src_code[1] = bus.src2_hazard_t;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = nRST ? fwd_decode(src_code[gi]) : FWD_REGFILE;
        end
    endgenerate

    // State register; reset lands in RUN from any state, including HALT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    // Next-state and enable/flush decode. Branch flushes are only honoured
    // in cycles where the front end actually advances.
    always_comb begin
        state_next   = state_reg;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.halt) begin
                    state_next = HALT;
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
                end else if (bus.dmem_req && !bus.dhit) begin
                    state_next = DWAIT;
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
                end else if (bus.src1_hazard_t == HZ_LOAD_USE ||
                             bus.src2_hazard_t == HZ_LOAD_USE) begin
                    state_next   = BUBBLE;
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (!bus.ihit) begin
                    state_next   = IWAIT;
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end else begin
                    ifid_flush_c = bus.branch_taken;
                end
            end
            BUBBLE: begin
                // One-shot: the dependent instruction now sees MEM/WB data.
                state_next   = RUN;
                ifid_flush_c = bus.branch_taken;
            end
            DWAIT: begin
                if (bus.dhit) begin
                    state_next   = RUN;
                    ifid_flush_c = bus.branch_taken;
                end else begin
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
                end
            end
            IWAIT: begin
                if (bus.dmem_req && !bus.dhit) begin
                    state_next = DWAIT;
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
                end else if (bus.ihit) begin
                    state_next   = RUN;
                    ifid_flush_c = bus.branch_taken;
                end else begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end
            end
            HALT: begin
                {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (!nRST) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b0;
            ifid_flush_c = 1'b0;
            idex_flush_c = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC was held outside HALT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count_reg <= '0;
        end else if (!pc_en_c && state_reg != HALT &&
                     stall_count_reg != {STALL_CNT_W{1'b1}}) begin
            stall_count_reg <= stall_count_reg + STALL_CNT_W'(1);
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.ifid_en     = ifid_en_c;
    assign bus.idex_en     = idex_en_c;
    assign bus.exmem_en    = exmem_en_c;
    assign bus.memwb_en    = memwb_en_c;
    assign bus.ifid_flush  = ifid_flush_c;
    assign bus.idex_flush  = idex_flush_c;
    assign bus.fwdA_sel    = fwd_sel[0];
    assign bus.fwdB_sel    = fwd_sel[1];
    assign bus.halted      = nRST && (state_reg == HALT);
    assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control with a 4-bit stall counter.
module tb_pipeline_control;

    localparam int W = 4;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    pipeline_control_if #(.STALL_CNT_W(W)) bus ();

    pipeline_control #(.STALL_CNT_W(W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] ctl();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                bus.memwb_en, bus.ifid_flush, bus.idex_flush};
    endfunction

    task automatic idle();
        bus.src1_hazard_t = 3'b000;
        bus.src2_hazard_t = 3'b000;
        bus.ihit          = 1'b1;
        bus.dhit          = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.halt          = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.src1_hazard_t = 3'b001;
        bus.src2_hazard_t = 3'b010;
        bus.ihit = 1'b1; bus.dmem_req = 1'b1; bus.dhit = 1'b0;
        bus.branch_taken = 1'b1; bus.halt = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        checks++; if (ctl() !== 7'b0000000) begin errors++; $display("FAIL rst_ctl got=%b exp=%b", ctl(), 7'b0000000); end
        checks++; if ({bus.fwdA_sel, bus.fwdB_sel} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got=%b exp=%b", {bus.fwdA_sel, bus.fwdB_sel}, 4'b0000); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.stall_count); end
        nRST = 1'b1;
        idle();
        #1;
        checks++; if (ctl() !== 7'b1111100) begin errors++; $display("FAIL rst_run_ctl got=%b exp=%b", ctl(), 7'b1111100); end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.src1_hazard_t = 3'b011;
        #1;
        checks++; if (ctl() !== 7'b0011101) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl(), 7'b0011101); end
        tick();
        bus.src1_hazard_t = 3'b100;
        #1;
        checks++; if (bus.fwdA_sel !== 2'b10) begin errors++; $display("FAIL lu_fwdA got=%b exp=10", bus.fwdA_sel); end
        checks++; if (ctl() !== 7'b1111100) begin errors++; $display("FAIL lu_bubble got=%b exp=%b", ctl(), 7'b1111100); end
        checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", bus.stall_count); end
        // second load-use, with the code still present in the BUBBLE cycle
        tick();
        bus.src2_hazard_t = 3'b011;
        bus.src1_hazard_t = 3'b000;
        #1;
        tick();
        #1;
        checks++; if (ctl() !== 7'b1111100) begin errors++; $display("FAIL lu_no_rebubble got=%b exp=%b", ctl(), 7'b1111100); end
        tick();
        #1;
        checks++; if (ctl() !== 7'b0011101) begin errors++; $display("FAIL lu_run_again got=%b exp=%b", ctl(), 7'b0011101); end
        idle();
        $display("test_load_use done");
    endtask

    task automatic test_dwait();
        do_reset();
        bus.dmem_req = 1'b1;
        bus.dhit     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl() !== 7'b0000000) begin errors++; $display("FAIL dwait_hold%0d got=%b exp=%b", i, ctl(), 7'b0000000); end
            tick();
        end
        bus.dhit = 1'b1;
        #1;
        checks++; if (ctl() !== 7'b1111100) begin errors++; $display("FAIL dwait_release got=%b exp=%b", ctl(), 7'b1111100); end
        tick();
        checks++; if (bus.stall_count !== 4'd3) begin errors++; $display("FAIL dwait_count got=%0d exp=3", bus.stall_count); end
        idle();
        $display("test_dwait done");
    endtask

    task automatic test_branch();
        do_reset();
        bus.branch_taken = 1'b1;
        #1;
        checks++; if (ctl() !== 7'b1111110) begin errors++; $display("FAIL br_flush got=%b exp=%b", ctl(), 7'b1111110); end
        tick();
        bus.branch_taken = 1'b0;
        #1;
        checks++; if (ctl() !== 7'b1111100) begin errors++; $display("FAIL br_oneshot got=%b exp=%b", ctl(), 7'b1111100); end
        tick();
        bus.branch_taken = 1'b1;
        bus.dmem_req = 1'b1;
        bus.dhit = 1'b0;
        #1;
        checks++; if (ctl() !== 7'b0000000) begin errors++; $display("FAIL br_with_dwait got=%b exp=%b", ctl(), 7'b0000000); end
        tick();
        #1;
        checks++; if (ctl() !== 7'b0000000) begin errors++; $display("FAIL br_in_dwait got=%b exp=%b", ctl(), 7'b0000000); end
        tick();
        bus.dhit = 1'b1;
        #1;
        checks++; if (ctl() !== 7'b1111110) begin errors++; $display("FAIL br_resample got=%b exp=%b", ctl(), 7'b1111110); end
        tick();
        idle();
        $display("test_branch done");
    endtask

    task automatic test_iwait();
        do_reset();
        bus.ihit = 1'b0;
        #1;
        checks++; if (ctl() !== 7'b0011101) begin errors++; $display("FAIL iw_enter got=%b exp=%b", ctl(), 7'b0011101); end
        tick();
        #1;
        checks++; if (ctl() !== 7'b0011101) begin errors++; $display("FAIL iw_hold got=%b exp=%b", ctl(), 7'b0011101); end
        bus.ihit = 1'b1;
        bus.branch_taken = 1'b1;
        #1;
        checks++; if (ctl() !== 7'b1111110) begin errors++; $display("FAIL iw_release got=%b exp=%b", ctl(), 7'b1111110); end
        tick();
        bus.branch_taken = 1'b0;
        bus.ihit = 1'b0;
        #1;
        tick();
        // IWAIT with a data miss pending moves to DWAIT
        bus.dmem_req = 1'b1;
        bus.dhit = 1'b0;
        #1;
        tick();
        bus.dmem_req = 1'b0;
        bus.ihit = 1'b1;
        #1;
        checks++; if (ctl() !== 7'b0000000) begin errors++; $display("FAIL iw_to_dwait got=%b exp=%b", ctl(), 7'b0000000); end
        idle();
        $display("test_iwait done");
    endtask

    task automatic test_halt();
        do_reset();
        bus.halt = 1'b1;
        bus.dmem_req = 1'b1;
        bus.dhit = 1'b0;
        #1;
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (bus.halted !== 1'b1 || ctl() !== 7'b0000000) begin errors++; $display("FAIL halt_hold%0d halted=%b ctl=%b exp halted=1 ctl=%b", i, bus.halted, ctl(), 7'b0000000); end
            tick();
        end
        do_reset();
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_clear got=%b exp=0", bus.halted); end
        checks++; if (ctl() !== 7'b1111100) begin errors++; $display("FAIL halt_run got=%b exp=%b", ctl(), 7'b1111100); end
        checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL halt_count got=%0d exp=0", bus.stall_count); end
        $display("test_halt done");
    endtask

    task automatic test_saturate();
        do_reset();
        bus.dmem_req = 1'b1;
        bus.dhit = 1'b0;
        repeat (14) tick();
        checks++; if (bus.stall_count !== 4'd14) begin errors++; $display("FAIL sat_preload got=%0d exp=14", bus.stall_count); end
        repeat (3) tick();
        checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", bus.stall_count); end
        idle();
        bus.dmem_req = 1'b1;
        bus.dhit = 1'b1;
        tick();
        idle();
        $display("test_saturate done");
    endtask

    task automatic test_fwd_sweep();
        logic [1:0] exp_sel [8];
        exp_sel = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.src2_hazard_t = 3'(i);
            bus.src1_hazard_t = 3'(7 - i);
            #1;
            checks++; if (bus.fwdB_sel !== exp_sel[i]) begin errors++; $display("FAIL fwdB_code%0d got=%b exp=%b", i, bus.fwdB_sel, exp_sel[i]); end
            checks++; if (bus.fwdA_sel !== exp_sel[7 - i]) begin errors++; $display("FAIL fwdA_code%0d got=%b exp=%b", 7 - i, bus.fwdA_sel, exp_sel[7 - i]); end
        end
        idle();
        $display("test_fwd_sweep done");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_dwait();
        test_branch();
        test_iwait();
        test_halt();
        test_saturate();
        test_fwd_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 The block SHALL have one parameter: STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and nRST.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 src1_hazard_t  input  3  hazard code for rs: 000 none, 001 fwd EX/MEM, 010 fwd MEM/WB, 011 load-use in EX/MEM, 100 load result in MEM/WB.
REQ-006 src2_hazard_t  input  3  hazard code for rt, same encoding as REQ-005.
REQ-007 ihit  input  1  instruction memory returned data this cycle.
REQ-008 dhit  input  1  data memory completed access this cycle.
REQ-009 dmem_req  input  1  MEM-stage instruction is a load or store.
REQ-010 branch_taken  input  1  branch or jump resolved taken this cycle.
REQ-011 halt  input  1  halt instruction reached MEM.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register enables.
REQ-013 ifid_flush, idex_flush  output  1 each  synchronous bubble insert into the named latch.
REQ-014 fwdA_sel, fwdB_sel  output  2 each  ALU operand mux select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-015 halted  output  1  sticky halt flag.
REQ-016 stall_count  output  STALL_CNT_W  saturating count of stalled cycles.

Function
REQ-017 The FSM SHALL have states RUN, BUBBLE, DWAIT, IWAIT, HALT; the state register SHALL update on the CLK rising edge, and all outputs SHALL be decoded combinationally from state and inputs.
REQ-018 RUN transition priority SHALL be: halt -> HALT; dmem_req && !dhit -> DWAIT; either src code 011 -> BUBBLE; !ihit -> IWAIT; otherwise remain in RUN.
REQ-019 In RUN with no stall condition, all enables SHALL be 1 and both flushes 0, except ifid_flush=1 when branch_taken=1.
REQ-020 In the RUN cycle that enters BUBBLE: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
REQ-021 BUBBLE SHALL last exactly one cycle, with all enables 1, and then return to RUN; a repeated 011 code in that cycle SHALL NOT re-enter BUBBLE.
REQ-022 In DWAIT, all enables SHALL be 0 until dhit=1; in the dhit cycle all enables SHALL be 1 and the next state SHALL be RUN.
REQ-023 In the RUN cycle that enters IWAIT, and in IWAIT with ihit=0: pc_en=0, ifid_en=0, idex_flush=1, and the downstream enables SHALL be 1.
REQ-024 In IWAIT with ihit=1, all enables SHALL be 1 and the next state SHALL be RUN; dmem_req && !dhit in IWAIT SHALL go to DWAIT.
REQ-025 branch_taken during a stall SHALL be ignored; it is resampled in the cycle the stall releases.
REQ-026 Forward select mapping SHALL be: 001->01, 010->10, 100->10, 000->00, 011->00; codes 101-111 SHALL map to 00.
REQ-027 HALT SHALL be absorbing until reset, with all enables 0, flushes 0 and halted=1.
REQ-028 stall_count SHALL increment on every cycle in which pc_en=0 and state != HALT, and SHALL saturate at all-ones.
REQ-029 When halt and the DWAIT condition occur together, HALT SHALL win.

Reset
REQ-030 While nRST=0: state=RUN, stall_count=0, halted=0, all enables 0, flushes 0, fwd selects 00.
REQ-031 Reset asserted in any state (including mid-DWAIT or HALT) SHALL return the block to RUN on the first rising edge after release.

Structure
REQ-032 The hazard code enum (HZ_NONE, HZ_FWD_MEM, HZ_FWD_WB, HZ_LOAD_USE, HZ_LOAD_WB) and the FSM state enum SHALL reside in cpu_types_pkg.
REQ-033 Ports SHALL be grouped in the interface pipeline_control_if; there SHALL be no sub-module, with the forwarding decode kept as an inline function.

Verification
REQ-034 Test 1: src1=011, ihit=1 -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle with src1=100 -> fwdA_sel=10, all enables 1; stall_count=1.
REQ-035 Test 2: dmem_req=1, dhit=0 for 3 cycles then 1 -> enables 0 for 3 cycles, 1 on the dhit cycle; stall_count=3.
REQ-036 Test 3: branch_taken=1 in RUN -> ifid_flush=1 for one cycle; with dmem_req=1, dhit=0 in the same cycle -> DWAIT, ifid_flush=0.
REQ-037 Test 4: halt=1 together with dmem_req=1, dhit=0 -> HALT, halted=1 stays set for 10 cycles; nRST pulse -> halted=0, state RUN.
REQ-038 Test 5: preload stall_count to all-ones minus 1 (STALL_CNT_W=4, 14 stalls), then 3 more stalls -> count holds 15.
REQ-039 Test 6: src2 sweeps 000-111 -> fwdB_sel 00,01,10,00,10,00,00,00.
